// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-port RAM between the CPU core (port 0) and the
//             program loader / debug port (port 1). Round-robin arbitration
//             when both request, one RAM access in flight at a time with a
//             fixed read latency, and completion returned as a one-cycle ack
//             pulse plus registered read data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W   address width of the RAM and both requester ports
//    DATA_W   data width
//    MEM_LAT  RAM read latency in cycles after mem_en is sampled (1..15)
//  Ports
//    clk            system clock, rising edge
//    rst_n          asynchronous active-low reset
//    i_req0/1       access request, held until the matching ack
//    i_we0/1        write enable, stable while request is high
//    i_addr0/1      address, stable while request is high
//    i_wdata0/1     write data, stable while request is high
//    o_ack0/1       one-cycle completion pulse
//    o_rdata        read data, valid in the ack cycle, held until next read
//    o_busy         high while an access is in flight
//    o_owner        port owning the current or last access
//    o_mem_en       RAM access strobe, one cycle per access
//    o_mem_we       RAM write enable, qualified by o_mem_en
//    o_mem_addr     RAM address
//    o_mem_wdata    RAM write data
//    i_mem_rdata    RAM read data
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_ack0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_owner,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int              C_CNT_W = 4;
  localparam logic [C_CNT_W-1:0] C_LAT = C_CNT_W'(MEM_LAT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_last;     // port granted most recently
  logic                 r_is_wr;    // current access is a write
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_ack0;
  logic                 r_ack1;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_busy;
  logic                 r_owner;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;

  // Winner selection: a lone requester always wins; under contention the
  // port that did not win last time goes first, giving strict alternation.
  logic                 w_any_req;
  logic                 w_grant1;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;

  assign w_any_req = i_req0 | i_req1;
  assign w_grant1  = i_req1 & (~i_req0 | ~r_last);
  assign w_we      = w_grant1 ? i_we1    : i_we0;
  assign w_addr    = w_grant1 ? i_addr1  : i_addr0;
  assign w_wdata   = w_grant1 ? i_wdata1 : i_wdata0;

  // Counter is loaded with MEM_LAT at grant and counts down one per edge in
  // WAIT; completion happens on the edge that finds it at zero, which is
  // MEM_LAT+1 edges after the grant edge. That leaves room for the RAM to
  // sample the strobe and then deliver data MEM_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;   // port 0 wins the first contest
      r_is_wr     <= 1'b0;
      r_cnt       <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_owner     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_any_req) begin
            r_owner     <= w_grant1;
            r_last      <= w_grant1;
            r_is_wr     <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_we    <= w_we;
            r_mem_wdata <= w_wdata;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= C_LAT;
            r_state     <= S_WAIT;
          end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
          end
        end

        S_WAIT: begin
          // One-cycle strobe: drop enable and write enable on first edge.
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_cnt == '0) begin
            if (!r_is_wr) begin
              r_rdata <= i_mem_rdata;
            end
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_owner     = r_owner;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Instance A (MEM_LAT=1)
//             talks to a behavioural RAM; instance B (MEM_LAT=3) has its
//             read data driven directly so capture timing can be pinned.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: MEM_LAT = 1 ----------------
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic       ack0, ack1, busy, owner, mem_en, mem_we;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] ram [256];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .o_ack0(ack0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .o_ack1(ack1),
    .o_rdata(rdata), .o_busy(busy), .o_owner(owner),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Behavioural RAM with one cycle of read latency after the strobe.
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- instance B: MEM_LAT = 3 ----------------
  logic       b_req0 = 0;
  logic [7:0] b_mrd = 8'h00;
  logic       b_ack0, b_ack1, b_busy, b_owner, b_mem_en, b_mem_we;
  logic [7:0] b_rdata, b_mem_addr, b_mem_wdata;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_req0(b_req0), .i_we0(1'b0), .i_addr0(8'h33), .i_wdata0(8'h00), .o_ack0(b_ack0),
    .i_req1(1'b0), .i_we1(1'b0), .i_addr1(8'h00), .i_wdata1(8'h00), .o_ack1(b_ack1),
    .o_rdata(b_rdata), .o_busy(b_busy), .o_owner(b_owner),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mrd)
  );

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // flags = {ack0, ack1, busy, mem_en, mem_we, owner}
  typedef struct {
    logic       req0; logic we0; logic [7:0] addr0; logic [7:0] wd0;
    logic       req1; logic we1; logic [7:0] addr1; logic [7:0] wd1;
    logic [5:0] flags; logic [7:0] rd; logic [7:0] ma; logic [7:0] mwd;
  } vec_t;

  vec_t tv [12];

  function automatic logic [29:0] outs_a();
    return {ack0, ack1, busy, mem_en, mem_we, owner, rdata, mem_addr, mem_wdata};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_exp;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'hA5;

    // ---- cycle-by-cycle table: CPU read, loader write, CPU read back ----
    //          req0 we0 addr0  wd0    req1 we1 addr1  wd1    flags      rd     ma     mwd
    tv[0]  = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 6'b001100, 8'h00, 8'h10, 8'h00};
    tv[1]  = '{1, 0, 8'h10, 8'h00, 1, 1, 8'h77, 8'h99, 6'b001000, 8'h00, 8'h10, 8'h00};
    tv[2]  = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 6'b100000, 8'hA5, 8'h10, 8'h00};
    tv[3]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 6'b000000, 8'hA5, 8'h10, 8'h00};
    tv[4]  = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 6'b001111, 8'hA5, 8'h20, 8'h3C};
    tv[5]  = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 6'b001001, 8'hA5, 8'h20, 8'h3C};
    tv[6]  = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 6'b010001, 8'hA5, 8'h20, 8'h3C};
    tv[7]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 6'b000001, 8'hA5, 8'h20, 8'h3C};
    tv[8]  = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 6'b001100, 8'hA5, 8'h20, 8'h00};
    tv[9]  = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 6'b001000, 8'hA5, 8'h20, 8'h00};
    tv[10] = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 6'b100000, 8'h3C, 8'h20, 8'h00};
    tv[11] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 6'b000000, 8'h3C, 8'h20, 8'h00};

    // ---- reset state ----
    #1;
    chk("reset_state_a", 64'(outs_a()), 64'(30'h0));
    chk("reset_state_b", 64'({b_ack0, b_ack1, b_busy, b_mem_en, b_rdata}), 64'(12'h0));
    do_reset();

    for (int i = 0; i < 12; i++) begin
      req0 = tv[i].req0; we0 = tv[i].we0; addr0 = tv[i].addr0; wdata0 = tv[i].wd0;
      req1 = tv[i].req1; we1 = tv[i].we1; addr1 = tv[i].addr1; wdata1 = tv[i].wd1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'(outs_a()),
          64'({tv[i].flags, tv[i].rd, tv[i].ma, tv[i].mwd}));
    end

    // ---- contention from reset: strict alternation 0,1,0,1 ----
    idle_inputs();
    req0 = 1; addr0 = 8'h10;
    req1 = 1; addr1 = 8'h20;
    do_reset();
    rd_exp = 8'h00;
    for (int c = 0; c < 12; c++) begin
      logic done, own;
      @(posedge clk); #1;
      done = ((c % 3) == 2);
      own  = ((c / 3) % 2) == 1;
      if (done) rd_exp = own ? 8'h3C : 8'hA5;
      chk($sformatf("contend_c%0d", c),
          64'({ack0, ack1, owner, mem_en, rdata}),
          64'({done & ~own, done & own, own, ((c % 3) == 0), rd_exp}));
    end

    // ---- reset asserted while the strobe is up ----
    idle_inputs();
    do_reset();
    req0 = 1; addr0 = 8'h20;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("pre_reset_read", 64'({ack0, rdata}), 64'({1'b1, 8'h3C}));
    addr0 = 8'h10;                   // new request presented in the ack cycle
    @(posedge clk); #1;
    chk("pre_reset_grant", 64'({mem_en, busy, owner, mem_addr}), 64'({1'b1, 1'b1, 1'b0, 8'h10}));
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 64'({mem_en, busy, ack0, ack1, rdata, owner}), 64'(13'h0));
    @(posedge clk); #1;
    chk("reset_hold_no_ack", 64'({mem_en, busy, ack0, ack1}), 64'(4'h0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_grant", 64'({mem_en, busy, owner, mem_addr}), 64'({1'b1, 1'b1, 1'b0, 8'h10}));
    @(posedge clk); @(posedge clk); #1;
    chk("post_reset_ack", 64'({ack0, ack1, owner, busy, rdata}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 8'hA5}));

    // ---- request withdrawn after grant; competing req1 waits for ack ----
    idle_inputs();
    do_reset();
    req0 = 1; addr0 = 8'h20;
    @(posedge clk); #1;
    chk("wd_grant", 64'({mem_en, owner, mem_addr}), 64'({1'b1, 1'b0, 8'h20}));
    req0 = 0; req1 = 1; addr1 = 8'h10;
    @(posedge clk); #1;
    chk("wd_wait", 64'({ack0, ack1, busy, mem_en, owner}), 64'(5'b00100));
    @(posedge clk); #1;
    chk("wd_ack0", 64'({ack0, ack1, mem_en, owner, rdata}), 64'({4'b1000, 8'h3C}));
    @(posedge clk); #1;
    chk("wd_req1_grant", 64'({ack0, mem_en, owner, mem_addr}), 64'({3'b011, 8'h10}));
    @(posedge clk); @(posedge clk); #1;
    chk("wd_ack1", 64'({ack0, ack1, rdata}), 64'({2'b01, 8'hA5}));
    req1 = 0;

    // ---- MEM_LAT = 3 timing on instance B ----
    b_req0 = 1;
    @(posedge clk); #1;                            // E0
    chk("lat3_strobe", 64'({b_mem_en, b_busy, b_mem_addr}), 64'({2'b11, 8'h33}));
    b_mrd = 8'h51;
    for (int k = 1; k <= 3; k++) begin             // E1..E3
      @(posedge clk); #1;
      chk($sformatf("lat3_wait_e%0d", k), 64'({b_ack0, b_mem_en, b_busy}), 64'(3'b001));
      b_mrd = 8'h51 + 8'(k);
    end
    @(posedge clk); #1;                            // E4
    chk("lat3_ack", 64'({b_ack0, b_ack1, b_busy, b_rdata}), 64'({3'b100, 8'h54}));
    b_req0 = 0;
    @(posedge clk); #1;
    chk("lat3_ack_pulse", 64'({b_ack0, b_mem_en, b_rdata}), 64'({2'b00, 8'h54}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
